// File: rtl/toggle_cmd_gen_pkg.sv
// toggle_cmd_gen_pkg: command codes, state encodings and code mapping shared by generator and receiver benches
package toggle_cmd_gen_pkg;
  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_TOGGLE = 2'b01;
  localparam logic [1:0] CMD_ARM    = 2'b10;
  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_TOGGLE = 2'd2,
    ST_GAP    = 2'd3
  } state_t;
  function automatic logic [1:0] cmd_of(state_t s);
    return s == ST_ARM ? CMD_ARM : s == ST_TOGGLE ? CMD_TOGGLE : CMD_HOLD;
  endfunction
endpackage

// File: rtl/toggle_cmd_gen_gap_timer.sv
// gap_timer: loadable down-counter timing the HOLD cycles between toggles, zero flag ends the gap
module gap_timer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic zero_o
);
  localparam int W = $clog2(GAP_CYCLES + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) cnt_q <= '0;
    else if (load_i) cnt_q <= W'(GAP_CYCLES - 1);
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/toggle_cmd_gen.sv
// toggle_cmd_gen: drives the 2-bit toggle-command stream and tracks the receiver level locally
module toggle_cmd_gen
  import toggle_cmd_gen_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rearm_i,
  input  logic             req_valid_i,
  input  logic [CNT_W-1:0] req_count_i,
  output logic             req_ready_o,
  output logic [1:0]       a_o,
  output logic             shadow_out_o,
  output logic             busy_o,
  output logic             done_o
);
  state_t state_q, state_d;
  logic [1:0] a_q;
  logic shadow_q, ready_q, busy_q, done_q, done_d, gap_zero;
  logic [CNT_W-1:0] rem_q, rem_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      // a_q still HOLD means ARM was entered from reset and 10 has not gone out yet
      ST_ARM:    state_d = a_q == CMD_ARM ? ST_IDLE : ST_ARM;
      ST_IDLE:   state_d = rearm_i ? ST_ARM : (req_valid_i && req_count_i != '0) ? ST_TOGGLE : ST_IDLE;
      ST_TOGGLE: state_d = rearm_i ? ST_ARM : rem_q == '0 ? ST_IDLE : GAP_CYCLES == 0 ? ST_TOGGLE : ST_GAP;
      ST_GAP:    state_d = rearm_i ? ST_ARM : gap_zero ? ST_TOGGLE : ST_GAP;
      default:   state_d = ST_ARM;
    endcase
    rem_d  = state_d == ST_ARM ? '0 :
             state_d == ST_TOGGLE ? (state_q == ST_IDLE ? req_count_i : rem_q) - CNT_W'(1) : rem_q;
    done_d = state_d == ST_IDLE && (state_q != ST_IDLE || (req_valid_i && !rearm_i));
  end
  generate
    if (GAP_CYCLES > 0) begin : g_gap
      logic gap_load;
      assign gap_load = state_d == ST_GAP && state_q != ST_GAP;
      gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (gap_load),
        .zero_o (gap_zero)
      );
    end else begin : g_nogap
      assign gap_zero = 1'b1;
    end
  endgenerate
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= ST_ARM;
      a_q      <= CMD_HOLD;
      shadow_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= cmd_of(state_d);
      shadow_q <= state_d == ST_ARM ? 1'b0 : shadow_q ^ (state_d == ST_TOGGLE);
      ready_q  <= state_d == ST_IDLE;
      busy_q   <= state_d != ST_IDLE;
      done_q   <= done_d;
      rem_q    <= rem_d;
    end
  end
  assign req_ready_o  = ready_q;
  assign a_o          = a_q;
  assign shadow_out_o = shadow_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_toggle_cmd_gen.sv
// tb_toggle_cmd_gen: directed bench for a GAP=1 and a GAP=0 generator, each paired with a receiver model
module tb_toggle_cmd_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rearm, vld, vld0;
  logic [3:0] cnt, cnt0;
  logic rdy1, sh1, busy1, done1, rdy0, sh0, busy0, done0;
  logic [1:0] a1, a0;
  logic lvl1, lvl0;
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  toggle_cmd_gen #(.CNT_W(4), .GAP_CYCLES(1)) d1 (
    .clk_i(clk), .reset_i(rst_n), .rearm_i(rearm), .req_valid_i(vld), .req_count_i(cnt),
    .req_ready_o(rdy1), .a_o(a1), .shadow_out_o(sh1), .busy_o(busy1), .done_o(done1)
  );
  toggle_cmd_gen #(.CNT_W(4), .GAP_CYCLES(0)) d0 (
    .clk_i(clk), .reset_i(rst_n), .rearm_i(1'b0), .req_valid_i(vld0), .req_count_i(cnt0),
    .req_ready_o(rdy0), .a_o(a0), .shadow_out_o(sh0), .busy_o(busy0), .done_o(done0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic rx(input logic lvl, input logic [1:0] a);
    return a == 2'b01 ? ~lvl : a == 2'b10 ? 1'b0 : lvl;
  endfunction
  // one clock edge, then receiver models consume this cycle's codes and shadows are compared
  task automatic step();
    @(posedge clk);
    #1;
    lvl1 = rst_n ? rx(lvl1, a1) : 1'b0;
    lvl0 = rst_n ? rx(lvl0, a0) : 1'b0;
    chk("shadow1_vs_rx", sh1, lvl1);
    chk("shadow0_vs_rx", sh0, lvl0);
  endtask
  logic [1:0] exp_a2 [5];
  logic       exp_s2 [5];
  initial begin
    exp_a2 = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    exp_s2 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    lvl1 = 1'b0; lvl0 = 1'b0;
    rst_n = 1'b0; rearm = 1'b0; vld = 1'b0; cnt = '0; vld0 = 1'b0; cnt0 = '0;
    // reset release
    step(); step();
    chk("rst_a", a1, 2'b00);
    chk("rst_busy", busy1, 1'b1);
    chk("rst_ready", rdy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_shadow", sh1, 1'b0);
    rst_n = 1'b1;
    step();
    chk("arm_a", a1, 2'b10);
    chk("arm_ready", rdy1, 1'b0);
    chk("arm_a0", a0, 2'b10);
    step();
    chk("arm_done_a", a1, 2'b00);
    chk("arm_done", done1, 1'b1);
    chk("arm_done_ready", rdy1, 1'b1);
    chk("arm_done_busy", busy1, 1'b0);
    chk("arm_done0", done0, 1'b1);
    // GAP=1, three toggles
    vld = 1'b1; cnt = 4'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      vld = 1'b0;
      chk("t3_a", a1, exp_a2[i]);
      chk("t3_shadow", sh1, exp_s2[i]);
      chk("t3_ready", rdy1, 1'b0);
      chk("t3_done", done1, 1'b0);
    end
    step();
    chk("t3_end_a", a1, 2'b00);
    chk("t3_end_ready", rdy1, 1'b1);
    chk("t3_end_done", done1, 1'b1);
    step();
    chk("t3_done_once", done1, 1'b0);
    // GAP=0, maximum count of fifteen back-to-back toggles
    vld0 = 1'b1; cnt0 = 4'd15;
    for (int i = 0; i < 15; i++) begin
      step();
      vld0 = 1'b0;
      chk("t15_a", a0, 2'b01);
      chk("t15_busy", busy0, 1'b1);
    end
    step();
    chk("t15_end_a", a0, 2'b00);
    chk("t15_end_done", done0, 1'b1);
    chk("t15_end_ready", rdy0, 1'b1);
    chk("t15_end_shadow", sh0, 1'b1);
    step();
    chk("t15_nowrap_a", a0, 2'b00);
    chk("t15_nowrap_busy", busy0, 1'b0);
    chk("t15_nowrap_done", done0, 1'b0);
    // rearm during the second gap of a five-toggle train
    vld = 1'b1; cnt = 4'd5;
    step(); vld = 1'b0;
    chk("ab_t1", a1, 2'b01);
    step(); chk("ab_g1", a1, 2'b00);
    step(); chk("ab_t2", a1, 2'b01);
    step(); chk("ab_g2", a1, 2'b00);
    rearm = 1'b1;
    step(); rearm = 1'b0;
    chk("ab_arm_a", a1, 2'b10);
    chk("ab_arm_shadow", sh1, 1'b0);
    chk("ab_arm_done", done1, 1'b0);
    step();
    chk("ab_idle_a", a1, 2'b00);
    chk("ab_idle_ready", rdy1, 1'b1);
    chk("ab_idle_arm_done", done1, 1'b1);
    vld = 1'b1; cnt = 4'd1;
    step(); vld = 1'b0;
    chk("ab_one_a", a1, 2'b01);
    chk("ab_one_shadow", sh1, 1'b1);
    step();
    chk("ab_one_done", done1, 1'b1);
    chk("ab_one_ready", rdy1, 1'b1);
    // rearm beats a simultaneous request, which is taken once IDLE returns
    rearm = 1'b1; vld = 1'b1; cnt = 4'd2;
    step(); rearm = 1'b0;
    chk("rv_arm_a", a1, 2'b10);
    chk("rv_arm_ready", rdy1, 1'b0);
    step();
    chk("rv_idle_a", a1, 2'b00);
    chk("rv_idle_ready", rdy1, 1'b1);
    step(); vld = 1'b0;
    chk("rv_t1", a1, 2'b01);
    step(); chk("rv_g1", a1, 2'b00);
    step(); chk("rv_t2", a1, 2'b01);
    chk("rv_shadow", sh1, 1'b0);
    step();
    chk("rv_done", done1, 1'b1);
    // zero-count request is a no-op with a single done
    vld = 1'b1; cnt = 4'd0;
    step(); vld = 1'b0;
    chk("z_a", a1, 2'b00);
    chk("z_busy", busy1, 1'b0);
    chk("z_done", done1, 1'b1);
    step();
    chk("z_done_once", done1, 1'b0);
    chk("z_a2", a1, 2'b00);
    // reset in the middle of a train
    vld = 1'b1; cnt = 4'd4;
    step(); vld = 1'b0;
    chk("mr_t1", a1, 2'b01);
    step(); chk("mr_g1", a1, 2'b00);
    rst_n = 1'b0;
    step();
    chk("mr_a", a1, 2'b00);
    chk("mr_busy", busy1, 1'b1);
    chk("mr_ready", rdy1, 1'b0);
    chk("mr_shadow", sh1, 1'b0);
    chk("mr_done", done1, 1'b0);
    rst_n = 1'b1;
    step();
    chk("mr_arm_a", a1, 2'b10);
    step();
    chk("mr_idle_a", a1, 2'b00);
    chk("mr_idle_done", done1, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
